// File: rtl/morse_tx_sequencer.sv
// Morse transmit sequencer: takes one character per handshake, drives the
// code/length LUT select, then keys out marks, element gaps and char gap.
module morse_tx_sequencer #(
  parameter int UNIT_CYCLES    = 12,
  parameter int CHAR_GAP_UNITS = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  input  logic       abort_i,
  output logic [2:0] lut_sel_o,
  input  logic [4:0] lut_code_i,
  input  logic [2:0] lut_len_i,
  output logic       key_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int MAX_U =
    (CHAR_GAP_UNITS > 3) ? CHAR_GAP_UNITS : 3;
  localparam int CNT_W = $clog2(MAX_U * UNIT_CYCLES + 1);

  localparam logic [CNT_W-1:0] T_DOT =
    CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_DASH =
    CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_CGAP =
    CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_GAP,
    S_CGAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [4:0]       r_shreg;
  logic [2:0]       r_rem;
  logic [2:0]       r_sel;
  logic             r_done;

  logic             w_accept;
  logic             w_tdone;
  logic [2:0]       w_len;

  assign char_ready_o = (r_state == S_IDLE) & ~rst_i;
  assign w_accept     = char_valid_i & char_ready_o;
  assign w_tdone      = (r_timer == '0);
  assign w_len        = (lut_len_i > 3'd4) ? 3'd4 : lut_len_i;

  assign lut_sel_o = r_sel;
  assign key_o     = (r_state == S_MARK);
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = r_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_shreg <= '0;
      r_rem   <= '0;
      r_sel   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_i && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_timer <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_sel   <= char_i;
              r_state <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_shreg <= lut_code_i;
            r_rem   <= w_len;
            r_timer <= lut_code_i[0] ? T_DASH : T_DOT;
            r_state <= S_MARK;
          end
          S_MARK: begin
            if (!w_tdone) begin
              r_timer <= r_timer - 1'b1;
            end else begin
              r_shreg <= r_shreg >> 1;
              if (r_rem == 3'd0) begin
                r_timer <= T_CGAP;
                r_state <= S_CGAP;
              end else begin
                r_rem   <= r_rem - 3'd1;
                r_timer <= T_DOT;
                r_state <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (!w_tdone) begin
              r_timer <= r_timer - 1'b1;
            end else begin
              r_timer <= r_shreg[0] ? T_DASH : T_DOT;
              r_state <= S_MARK;
            end
          end
          S_CGAP: begin
            if (!w_tdone) begin
              r_timer <= r_timer - 1'b1;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer with a small A..H code table.
// Per-cycle key/done/ready/busy traces are compared against hand masks.
module tb_morse_tx_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] char_i;
  logic       char_valid_i;
  logic       char_ready_o;
  logic       abort_i;
  logic [2:0] lut_sel_o;
  logic [4:0] lut_code_i;
  logic [2:0] lut_len_i;
  logic       key_o;
  logic       busy_o;
  logic       done_o;

  logic       ovr;
  logic [4:0] ovr_code;
  logic [2:0] ovr_len;

  int checks;
  int errors;

  always #5 clk_i = ~clk_i;

  morse_tx_sequencer #(
    .UNIT_CYCLES   (2),
    .CHAR_GAP_UNITS(3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .char_i      (char_i),
    .char_valid_i(char_valid_i),
    .char_ready_o(char_ready_o),
    .abort_i     (abort_i),
    .lut_sel_o   (lut_sel_o),
    .lut_code_i  (lut_code_i),
    .lut_len_i   (lut_len_i),
    .key_o       (key_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // index 0..7 = A..H, bit0 first element, 1 = dash
  always_comb begin
    lut_code_i = 5'b00000;
    lut_len_i  = 3'd0;
    case (lut_sel_o)
      3'd0: begin lut_code_i = 5'b00010; lut_len_i = 3'd1; end
      3'd1: begin lut_code_i = 5'b00001; lut_len_i = 3'd3; end
      3'd2: begin lut_code_i = 5'b00101; lut_len_i = 3'd3; end
      3'd3: begin lut_code_i = 5'b00001; lut_len_i = 3'd2; end
      3'd4: begin lut_code_i = 5'b00000; lut_len_i = 3'd0; end
      3'd5: begin lut_code_i = 5'b00100; lut_len_i = 3'd3; end
      3'd6: begin lut_code_i = 5'b00011; lut_len_i = 3'd2; end
      default: begin lut_code_i = 5'b00000; lut_len_i = 3'd3; end
    endcase
    if (ovr) begin
      lut_code_i = ovr_code;
      lut_len_i  = ovr_len;
    end
  end

  task automatic run(
    input string       nm,
    input logic [2:0]  c0,
    input bit          two,
    input logic [2:0]  c1,
    input int          ncyc,
    input logic [63:0] ekey,
    input logic [63:0] edone,
    input logic [63:0] erdy,
    input int          abort_at,
    input bit          tog
  );
    logic [63:0] key_m, done_m, rdy_m, busy_m, win;
    logic [2:0]  sel1;
    bit          sent;
    key_m = '0; done_m = '0; rdy_m = '0; busy_m = '0;
    sel1 = 3'bx;
    sent = 1'b0;
    win = (64'd1 << (ncyc + 1)) - 64'd1;
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk_i);
      key_m[k]  = key_o;
      done_m[k] = done_o;
      rdy_m[k]  = char_ready_o;
      busy_m[k] = busy_o;
      if (k == 1) sel1 = lut_sel_o;
      abort_i = (k == abort_at);
      if (k == 0) begin
        char_valid_i = 1'b1;
        char_i = c0;
      end else if (two && !sent) begin
        char_valid_i = 1'b1;
        char_i = c1;
        if (char_ready_o) sent = 1'b1;
      end else if (tog && k < ncyc) begin
        char_valid_i = k[0];
        char_i = 3'($urandom);
      end else begin
        char_valid_i = 1'b0;
      end
    end
    char_valid_i = 1'b0;
    abort_i = 1'b0;
    checks++;
    if (key_m !== ekey) begin
      errors++;
      $display("FAIL %s key got %h exp %h", nm, key_m, ekey);
    end
    checks++;
    if (done_m !== edone) begin
      errors++;
      $display("FAIL %s done got %h exp %h", nm, done_m, edone);
    end
    checks++;
    if (rdy_m !== erdy) begin
      errors++;
      $display("FAIL %s ready got %h exp %h", nm, rdy_m, erdy);
    end
    checks++;
    if (busy_m !== (~erdy & win)) begin
      errors++;
      $display("FAIL %s busy got %h exp %h", nm, busy_m, ~erdy & win);
    end
    checks++;
    if (sel1 !== c0) begin
      errors++;
      $display("FAIL %s lut_sel got %0d exp %0d", nm, sel1, c0);
    end
  endtask

  function automatic logic [63:0] b(input int n);
    return 64'd1 << n;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if ({key_o, busy_o, done_o, char_ready_o} !== 4'b0000) begin
        errors++;
        $display("FAIL reset k/b/d/r got %b exp 0000",
                 {key_o, busy_o, done_o, char_ready_o});
      end
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({char_ready_o, busy_o, lut_sel_o} !== 5'b10000) begin
      errors++;
      $display("FAIL post_reset r/b/sel got %b exp 10000",
               {char_ready_o, busy_o, lut_sel_o});
    end
  endtask

  task automatic test_char_a();
    run("A", 3'd0, 0, 3'd0, 18, 64'h0FCC,
        b(18), b(0) | b(18), -1, 0);
  endtask

  task automatic test_char_e_abort_idle();
    run("E_abort_idle", 3'd4, 0, 3'd0, 10, 64'hC,
        b(10), b(0) | b(10), 0, 0);
  endtask

  task automatic test_back_to_back();
    run("H_then_B", 3'd7, 1, 3'd1, 48,
        64'hCCCC | (64'hCCCFC << 22),
        b(22) | b(48), b(0) | b(22) | b(48), -1, 0);
  endtask

  task automatic test_abort();
    run("B_abort", 3'd1, 0, 3'd0, 8, 64'h3C,
        64'h0, b(0) | b(6) | b(7) | b(8), 5, 0);
    run("C_after", 3'd2, 0, 3'd0, 30, 64'hCFCCFC,
        b(30), b(0) | b(30), -1, 0);
  endtask

  task automatic test_ignore_valid();
    run("D_toggle", 3'd3, 0, 3'd0, 22, 64'hCCFC,
        b(22), b(0) | b(22), -1, 1);
  endtask

  task automatic test_len_clamp();
    ovr = 1'b1; ovr_code = 5'b11111; ovr_len = 3'd7;
    run("clamp", 3'd5, 0, 3'd0, 46, 64'h000000FC_FCFCFCFC,
        b(46), b(0) | b(46), -1, 0);
    ovr_code = 5'b11110; ovr_len = 3'd0;
    run("high_bits", 3'd6, 0, 3'd0, 10, 64'hC,
        b(10), b(0) | b(10), -1, 0);
    ovr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk_i);
    char_valid_i = 1'b1; char_i = 3'd7;
    @(negedge clk_i);
    char_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (key_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_key_pre got %b exp 1", key_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({key_o, busy_o, done_o, char_ready_o} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset k/b/d/r got %b exp 0000",
               {key_o, busy_o, done_o, char_ready_o});
    end
    rst_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done_o || key_o || !char_ready_o) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_reset_quiet got activity exp idle");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i = 1'b1;
    char_i = 3'd0;
    char_valid_i = 1'b0;
    abort_i = 1'b0;
    ovr = 1'b0;
    ovr_code = 5'd0;
    ovr_len = 3'd0;
    test_reset();
    test_char_a();
    test_char_e_abort_idle();
    test_back_to_back();
    test_abort();
    test_ignore_valid();
    test_len_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
